// File: rtl/vga_text_writer_if.sv
// CPU-side byte bus and RAM write port of the VGA text writer.
// The writer takes the slave modport; the CPU/test side takes the master modport.
interface vga_text_writer_if;
  logic [7:0]  cpu_data;
  logic        cpu_reg;
  logic        cpu_wr;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        fifo_full;
  logic        overflow;
  logic [5:0]  cur_row;
  logic [5:0]  cur_col;

  modport slave (
    input  cpu_data, cpu_reg, cpu_wr,
    output wr_addr, wr_data, wr_en, busy, fifo_full, overflow, cur_row, cur_col
  );

  modport master (
    output cpu_data, cpu_reg, cpu_wr,
    input  wr_addr, wr_data, wr_en, busy, fifo_full, overflow, cur_row, cur_col
  );
endinterface

// File: rtl/vga_text_writer.sv
// Character-stream front end for the VGA text display: buffers CPU bytes, decodes
// control codes, and writes glyph/attribute pairs into the character/colour RAM.
module vga_text_writer #(
  parameter int         COLS       = 50,
  parameter int         ROWS       = 37,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] ATTR_RESET = 8'hF0
) (
  input  logic             clk_20MHz,
  input  logic             n_reset,
  vga_text_writer_if.slave bus
);

  localparam int               PTR_W    = $clog2(FIFO_DEPTH);
  localparam int               CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [5:0]       LAST_COL = 6'(COLS - 1);
  localparam logic [5:0]       LAST_ROW = 6'(ROWS - 1);
  localparam logic [7:0]       SPACE    = 8'h20;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WR_CHAR,
    S_WR_ATTR,
    S_NEWLINE,
    S_CLR_ROW,
    S_CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [8:0]       fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full_q, fifo_full_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;

  logic             head_reg_q, head_reg_d;
  logic [7:0]       head_data_q, head_data_d;
  logic [7:0]       attr_q, attr_d;
  logic [5:0]       row_q, row_d;
  logic [5:0]       col_q, col_d;
  logic [5:0]       clr_row_q, clr_row_d;
  logic [5:0]       clr_col_q, clr_col_d;
  logic             clr_phase_q, clr_phase_d;

  logic [12:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;

  // A strobe against a full FIFO is lost even if the FSM pops in the same cycle.
  assign push = bus.cpu_wr && (count_q != FULL_CNT);
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (bus.cpu_wr && !push) overflow_d = 1'b1;
    fifo_full_d = (count_d == FULL_CNT);
  end

  always_ff @(posedge clk_20MHz) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {bus.cpu_reg, bus.cpu_data};
  end

  // Write-port outputs are decided one cycle ahead so the RAM sees registered signals.
  always_comb begin
    state_d     = state_q;
    head_reg_d  = head_reg_q;
    head_data_d = head_data_q;
    attr_d      = attr_q;
    row_d       = row_q;
    col_d       = col_q;
    clr_row_d   = clr_row_q;
    clr_col_d   = clr_col_q;
    clr_phase_d = clr_phase_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {head_reg_d, head_data_d} = fifo_mem_q[rd_ptr_q];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_IDLE;
        if (head_reg_q) begin
          attr_d = head_data_q;
        end else begin
          case (head_data_q)
            8'h0D: col_d = '0;
            8'h0A: state_d = S_NEWLINE;
            8'h08: if (col_q != '0) col_d = col_q - 1'b1;
            8'h0C: begin
              clr_row_d   = '0;
              clr_col_d   = '0;
              clr_phase_d = 1'b0;
              state_d     = S_CLEAR;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = {1'b0, row_q, col_q};
              wr_data_d = head_data_q;
              state_d   = S_WR_CHAR;
            end
          endcase
        end
      end

      S_WR_CHAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = {1'b1, row_q, col_q};
        wr_data_d = attr_q;
        state_d   = S_WR_ATTR;
      end

      S_WR_ATTR: begin
        if (col_q == LAST_COL) begin
          state_d = S_NEWLINE;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = S_IDLE;
        end
      end

      // No scrolling: the row below (or row 0 after the last) is blanked in place.
      S_NEWLINE: begin
        col_d       = '0;
        row_d       = (row_q == LAST_ROW) ? 6'd0 : row_q + 1'b1;
        clr_col_d   = '0;
        clr_phase_d = 1'b0;
        state_d     = S_CLR_ROW;
      end

      S_CLR_ROW: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = {clr_phase_q, row_q, clr_col_q};
        wr_data_d   = clr_phase_q ? attr_q : SPACE;
        clr_phase_d = ~clr_phase_q;
        if (clr_phase_q) begin
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            state_d   = S_IDLE;
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end

      S_CLEAR: begin
        wr_en_d     = 1'b1;
        wr_addr_d   = {clr_phase_q, clr_row_q, clr_col_q};
        wr_data_d   = clr_phase_q ? attr_q : SPACE;
        clr_phase_d = ~clr_phase_q;
        if (clr_phase_q) begin
          if (clr_col_q == LAST_COL) begin
            clr_col_d = '0;
            if (clr_row_q == LAST_ROW) begin
              clr_row_d = '0;
              row_d     = '0;
              col_d     = '0;
              state_d   = S_IDLE;
            end else begin
              clr_row_d = clr_row_q + 1'b1;
            end
          end else begin
            clr_col_d = clr_col_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE) || (count_d != '0) || wr_en_d;
  end

  always_ff @(posedge clk_20MHz or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_CLEAR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_q <= 1'b0;
      overflow_q  <= 1'b0;
      head_reg_q  <= 1'b0;
      head_data_q <= '0;
      attr_q      <= ATTR_RESET;
      row_q       <= '0;
      col_q       <= '0;
      clr_row_q   <= '0;
      clr_col_q   <= '0;
      clr_phase_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_full_q <= fifo_full_d;
      overflow_q  <= overflow_d;
      head_reg_q  <= head_reg_d;
      head_data_q <= head_data_d;
      attr_q      <= attr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      clr_row_q   <= clr_row_d;
      clr_col_q   <= clr_col_d;
      clr_phase_q <= clr_phase_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.busy      = busy_q;
  assign bus.fifo_full = fifo_full_q;
  assign bus.overflow  = overflow_q;
  assign bus.cur_row   = row_q;
  assign bus.cur_col   = col_q;

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: a cursor/attribute model queues the
// expected RAM writes, and a negedge monitor pops and compares every wr_en cycle.
module tb_vga_text_writer;

  localparam int COLS = 50;
  localparam int ROWS = 37;

  logic clk;
  logic n_reset;

  vga_text_writer_if bus ();

  vga_text_writer dut (
    .clk_20MHz (clk),
    .n_reset   (n_reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  logic [20:0] exp_q[$];
  int n_compared   = 0;
  int n_mismatched = 0;
  int wr_count     = 0;
  int m_row  = 0;
  int m_col  = 0;
  logic [7:0] m_attr = 8'hF0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (n_reset && bus.wr_en) begin
      wr_count++;
      n_compared++;
      assert (exp_q.size() != 0) else begin
        n_mismatched++;
        $error("FAIL unexpected_write observed=%0h_%0h expected=none", bus.wr_addr, bus.wr_data);
      end
      if (exp_q.size() != 0) check("ram_write", {11'd0, bus.wr_addr, bus.wr_data}, {11'd0, exp_q.pop_front()});
    end
  end

  task automatic exp_write(input int plane, input int r, input int c, input logic [7:0] d);
    exp_q.push_back({1'(plane), 6'(r), 6'(c), d});
  endtask

  task automatic model_clear_row(input int r);
    for (int cc = 0; cc < COLS; cc++) begin
      exp_write(0, r, cc, 8'h20);
      exp_write(1, r, cc, m_attr);
    end
  endtask

  task automatic model_newline();
    m_col = 0;
    m_row = (m_row == ROWS - 1) ? 0 : m_row + 1;
    model_clear_row(m_row);
  endtask

  task automatic model_byte(input logic r, input logic [7:0] d);
    if (r) begin
      m_attr = d;
    end else begin
      case (d)
        8'h0D: m_col = 0;
        8'h0A: model_newline();
        8'h08: if (m_col > 0) m_col--;
        8'h0C: begin
          for (int rr = 0; rr < ROWS; rr++) model_clear_row(rr);
          m_row = 0;
          m_col = 0;
        end
        default: begin
          exp_write(0, m_row, m_col, d);
          exp_write(1, m_row, m_col, m_attr);
          if (m_col == COLS - 1) model_newline();
          else m_col++;
        end
      endcase
    end
  endtask

  // Called just after a negedge; the strobe covers exactly one rising edge.
  task automatic push_byte(input logic r, input logic [7:0] d);
    bus.cpu_wr   = 1'b1;
    bus.cpu_reg  = r;
    bus.cpu_data = d;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic applyStimulus(input logic r, input logic [7:0] d);
    int n = 0;
    while (bus.fifo_full && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_compared++;
      n_mismatched++;
      $error("FAIL fifo_drain_timeout observed=%0d expected<2000", n);
    end
    push_byte(r, d);
    model_byte(r, d);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || exp_q.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    n_compared++;
    assert (n < max_cycles) else begin
      n_mismatched++;
      $error("FAIL %s_timeout observed=%0d cycles pending=%0d expected=idle", tag, n, exp_q.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int base;
    bus.cpu_wr   = 1'b0;
    bus.cpu_reg  = 1'b0;
    bus.cpu_data = 8'h00;
    n_reset      = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wr_en",     32'(bus.wr_en),     32'd0);
    check("rst_wr_addr",   32'(bus.wr_addr),   32'd0);
    check("rst_wr_data",   32'(bus.wr_data),   32'd0);
    check("rst_overflow",  32'(bus.overflow),  32'd0);
    check("rst_fifo_full", 32'(bus.fifo_full), 32'd0);
    check("rst_cur_row",   32'(bus.cur_row),   32'd0);
    check("rst_cur_col",   32'(bus.cur_col),   32'd0);

    // Full-screen clear after reset release
    model_byte(1'b0, 8'h0C);
    n_reset = 1'b1;
    wait_idle("reset_clear", 5000);
    check("clear_write_count", 32'(wr_count), 32'd3700);
    check("clear_cur_row",     32'(bus.cur_row), 32'd0);
    check("clear_cur_col",     32'(bus.cur_col), 32'd0);
    check("clear_busy",        32'(bus.busy),    32'd0);

    // First printable, with cycle-exact latency
    push_byte(1'b0, 8'h41);
    model_byte(1'b0, 8'h41);
    check("lat_e0_wr_en", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    check("lat_e1_wr_en", 32'(bus.wr_en), 32'd0);
    @(negedge clk);
    check("lat_e2_char", {18'd0, bus.wr_en, bus.wr_addr}, {18'd0, 1'b1, 13'h0000});
    @(negedge clk);
    check("lat_e3_attr", {18'd0, bus.wr_en, bus.wr_addr}, {18'd0, 1'b1, 13'h1000});
    @(negedge clk);
    check("lat_e4_wr_en", 32'(bus.wr_en), 32'd0);
    wait_idle("char_a", 100);
    check("a_cur_col", 32'(bus.cur_col), 32'd1);

    // Attribute change applies to the following glyph
    applyStimulus(1'b1, 8'h9C);
    applyStimulus(1'b0, 8'h42);
    wait_idle("attr_b", 200);
    check("b_cur_col", 32'(bus.cur_col), 32'd2);

    // CR, then a full line with auto-wrap and row clear
    applyStimulus(1'b0, 8'h0D);
    for (int i = 0; i < 49; i++) applyStimulus(1'b0, 8'(8'h21 + i));
    applyStimulus(1'b0, 8'h5A);
    wait_idle("wrap", 2000);
    check("wrap_cur_row", 32'(bus.cur_row), 32'd1);
    check("wrap_cur_col", 32'(bus.cur_col), 32'd0);

    // Walk to (36,5), then LF wraps to row 0
    for (int i = 0; i < 35; i++) applyStimulus(1'b0, 8'h0A);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h61 + 8'(i));
    wait_idle("walk", 8000);
    check("walk_cur_row", 32'(bus.cur_row), 32'd36);
    check("walk_cur_col", 32'(bus.cur_col), 32'd5);
    applyStimulus(1'b0, 8'h0A);
    wait_idle("lf_wrap", 500);
    check("lf_cur_row", 32'(bus.cur_row), 32'd0);
    check("lf_cur_col", 32'(bus.cur_col), 32'd0);

    // Overflow during CLEAR: only the first 16 of 20 strobes survive
    applyStimulus(1'b0, 8'h0C);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      push_byte(1'b0, 8'h41 + 8'(i));
      if (i < 16) model_byte(1'b0, 8'h41 + 8'(i));
    end
    check("ovf_fifo_full", 32'(bus.fifo_full), 32'd1);
    check("ovf_overflow",  32'(bus.overflow),  32'd1);
    wait_idle("ovf_drain", 6000);
    check("ovf_sticky",  32'(bus.overflow), 32'd1);
    check("ovf_cur_col", 32'(bus.cur_col),  32'd16);

    // Backspace at column 0 neither writes nor moves
    applyStimulus(1'b0, 8'h0D);
    wait_idle("cr", 100);
    base = wr_count;
    applyStimulus(1'b0, 8'h08);
    wait_idle("bs", 100);
    check("bs_no_write", 32'(wr_count - base), 32'd0);
    check("bs_cur_col",  32'(bus.cur_col),     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
